frame_task_scheduler: RTL

- Derives a programmable-rate frame tick from the VGA vertical-sync signal.
- On each tick, sequences a set of per-frame game-logic clients (sprite movers, collision, score update) one at a time.
- Each client is launched with a start pulse; the scheduler then waits for its done pulse or a timeout before moving on.
- Sits between the VGA controller and the game-logic engines, replacing free-running frame clocks with an ordered, checked per-frame schedule.

---
 rtl/frame_task_scheduler.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/frame_task_scheduler.sv
// Frame-rate task scheduler: derives a divided tick from VGA vsync and runs the
// enabled game-logic clients one at a time, each with a start/done handshake and a timeout.
module frame_task_scheduler #(
    parameter int NUM_CLIENTS    = 4,
    parameter int DIV_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int IDX_W         = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   VGA_VS,
    input  logic [DIV_WIDTH-1:0]   frame_div,
    input  logic                   enable,
    input  logic [NUM_CLIENTS-1:0] client_en,
    input  logic [NUM_CLIENTS-1:0] done,
    input  logic                   clr_err,
    output logic [NUM_CLIENTS-1:0] start,
    output logic                   tick,
    output logic                   busy,
    output logic [IDX_W-1:0]       active_client,
    output logic [15:0]            frame_count,
    output logic                   overrun,
    output logic [NUM_CLIENTS-1:0] timeout_err
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_NEXT} state_t;

    state_t                 state;
    logic                   vs_sync1, vs_sync2, vs_hist, vs_rise_q;
    logic [DIV_WIDTH-1:0]   div_cnt;
    logic [DIV_WIDTH:0]     div_target, div_inc;
    logic [NUM_CLIENTS-1:0] pending;
    logic [TW-1:0]          tmo_cnt;

    function automatic logic [IDX_W-1:0] lowest_bit(input logic [NUM_CLIENTS-1:0] mask);
        lowest_bit = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--)
            if (mask[i]) lowest_bit = IDX_W'(i);
    endfunction

    function automatic logic [NUM_CLIENTS-1:0] one_hot(input logic [IDX_W-1:0] idx);
        one_hot = NUM_CLIENTS'(1) << idx;
    endfunction

    always_comb begin
        div_target = (frame_div == '0) ? (DIV_WIDTH+1)'(1) : {1'b0, frame_div};
        div_inc    = {1'b0, div_cnt} + (DIV_WIDTH+1)'(1);
    end

    // VS synchronizer, edge detect and divider. Sync flops reset high so a
    // VS held high through reset is not seen as a rising edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            vs_sync1    <= 1'b1;
            vs_sync2    <= 1'b1;
            vs_hist     <= 1'b1;
            vs_rise_q   <= 1'b0;
            div_cnt     <= '0;
            tick        <= 1'b0;
            frame_count <= '0;
        end else begin
            vs_sync1  <= VGA_VS;
            vs_sync2  <= vs_sync1;
            vs_hist   <= vs_sync2;
            vs_rise_q <= vs_sync2 & ~vs_hist;
            tick      <= 1'b0;
            if (vs_rise_q) begin
                if (div_inc >= div_target) begin
                    tick        <= 1'b1;
                    div_cnt     <= '0;
                    frame_count <= frame_count + 16'd1;
                end else begin
                    div_cnt <= div_inc[DIV_WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= S_IDLE;
            pending       <= '0;
            tmo_cnt       <= '0;
            start         <= '0;
            busy          <= 1'b0;
            active_client <= '0;
            overrun       <= 1'b0;
            timeout_err   <= '0;
        end else begin
            start <= '0;
            // NOTE: clears are written before sets; the later non-blocking
            // assignment wins, so a same-cycle error event beats clr_err.
            if (clr_err) begin
                overrun     <= 1'b0;
                timeout_err <= '0;
            end
            if (tick && state != S_IDLE)
                overrun <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (tick && enable && client_en != '0) begin
                        pending       <= client_en;
                        active_client <= lowest_bit(client_en);
                        start         <= one_hot(lowest_bit(client_en));
                        busy          <= 1'b1;
                        state         <= S_START;
                    end
                end
                S_START: begin
                    tmo_cnt <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (done[active_client]) begin
                        pending[active_client] <= 1'b0;
                        state                  <= S_NEXT;
                    end else if (tmo_cnt == TMO_LAST) begin
                        timeout_err[active_client] <= 1'b1;
                        pending[active_client]     <= 1'b0;
                        state                      <= S_NEXT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_NEXT: begin
                    if (pending != '0) begin
                        active_client <= lowest_bit(pending);
                        start         <= one_hot(lowest_bit(pending));
                        state         <= S_START;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
